// File: rtl/instruction_prefetch_queue_if.sv
// Fetch-side bundle: redirect input, instruction-memory request/response and
// the decode-side queue handshake. master = prefetch queue, slave = its environment.
interface instruction_prefetch_queue_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int INST_WIDTH = 32
);
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  imem_req_valid;
  logic [ADDR_WIDTH-1:0] imem_req_addr;
  logic                  imem_req_ready;
  logic                  imem_resp_valid;
  logic [INST_WIDTH-1:0] imem_resp_inst;
  logic                  inst_valid;
  logic [INST_WIDTH-1:0] inst;
  logic [ADDR_WIDTH-1:0] inst_pc;
  logic                  inst_ready;

  modport master (
    input  redirect, redirect_pc,
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_resp_valid, imem_resp_inst,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    output redirect, redirect_pc,
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_resp_valid, imem_resp_inst,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );
endinterface

// File: rtl/instruction_prefetch_queue.sv
// Sequential instruction prefetcher: credit-checked requests to a variable-latency
// memory, PC-tagged response FIFO toward decode, redirect flush with stale-response drain.
module instruction_prefetch_queue #(
  parameter int                  ADDR_WIDTH = 64,
  parameter int                  INST_WIDTH = 32,
  parameter int                  DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic reset,
  instruction_prefetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t                state, state_next;
  logic [CW-1:0]         count, count_next;
  logic [CW-1:0]         outstanding, outstanding_next;
  logic [CW-1:0]         stale, stale_next;
  logic [PW-1:0]         rd_ptr, wr_ptr, rd_ptr_next;
  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem   [DEPTH];
  logic [ADDR_WIDTH-1:0] fetch_pc, resp_pc, head_pc, redirect_base;
  logic [INST_WIDTH-1:0] head_inst;
  logic                  req_valid, req_fire, resp_fire, enq, deq;

  assign resp_fire     = bus.imem_resp_valid;
  assign req_fire      = req_valid && bus.imem_req_ready;
  assign redirect_base = {bus.redirect_pc[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= FETCH;
    else        state <= state_next;
  end

  // At most one of stale/outstanding is nonzero, so a single sum covers both states on redirect.
  always_comb begin
    state_next       = state;
    req_valid        = 1'b0;
    outstanding_next = outstanding;
    stale_next       = stale;
    case (state)
      FETCH: begin
        req_valid        = reset && ((count + outstanding) < DEPTH_C);
        outstanding_next = outstanding + CW'(req_fire) - CW'(resp_fire);
      end
      DRAIN: begin
        if (resp_fire) begin
          stale_next = stale - CW'(1);
          if (stale_next == '0) state_next = FETCH;
        end
      end
      default: state_next = FETCH;
    endcase
    if (bus.redirect) begin
      stale_next       = stale + outstanding + CW'(req_fire) - CW'(resp_fire);
      outstanding_next = '0;
      state_next       = (stale_next != '0) ? DRAIN : FETCH;
    end
  end

  assign enq         = (state == FETCH) && resp_fire && !bus.redirect;
  assign deq         = (count != '0) && bus.inst_ready;
  assign count_next  = count + CW'(enq) - CW'(deq);
  assign rd_ptr_next = rd_ptr + PW'(deq);

  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[wr_ptr] <= bus.imem_resp_inst;
      pc_mem[wr_ptr]   <= resp_pc;
    end
  end

  // Head registers hold the last value when the queue drains or is flushed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      stale       <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      head_inst   <= '0;
      head_pc     <= '0;
    end else begin
      outstanding <= outstanding_next;
      stale       <= stale_next;
      if (bus.redirect) begin
        fetch_pc <= redirect_base;
        resp_pc  <= redirect_base;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + ADDR_WIDTH'(4);
        if (enq) begin
          resp_pc <= resp_pc + ADDR_WIDTH'(4);
          wr_ptr  <= wr_ptr + PW'(1);
        end
        count  <= count_next;
        rd_ptr <= rd_ptr_next;
        if (count_next != '0) begin
          if (enq && (wr_ptr == rd_ptr_next)) begin
            head_inst <= bus.imem_resp_inst;
            head_pc   <= resp_pc;
          end else begin
            head_inst <= inst_mem[rd_ptr_next];
            head_pc   <= pc_mem[rd_ptr_next];
          end
        end
      end
    end
  end

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = fetch_pc;
  assign bus.inst_valid     = (count != '0);
  assign bus.inst           = head_inst;
  assign bus.inst_pc        = head_pc;
endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Bench for instruction_prefetch_queue: directed vector table, corner-case sequences,
// and randomized traffic against an epoch-tagged reference model with an in-order memory.
module tb_instruction_prefetch_queue;
  localparam int AW = 64;
  localparam int IW = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instruction_prefetch_queue_if #(.ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();

  instruction_prefetch_queue #(
    .ADDR_WIDTH(AW), .INST_WIDTH(IW), .DEPTH(DEPTH), .RESET_PC(64'h0)
  ) dut (
    .clk(clk), .reset(rst_n), .bus(bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct { logic [63:0] addr; int epoch; int due; } req_t;
  typedef struct { logic [63:0] pc; logic [31:0] inst; } ent_t;
  typedef struct {
    bit rr; bit rv; logic [63:0] ra; bit ir;
    bit e_rqv; logic [63:0] e_addr; bit e_iv; logic [63:0] e_pc;
  } vec_t;

  req_t        mem_q[$];
  ent_t        model_q[$];
  logic [63:0] m_fetch;
  logic [63:0] last_pc;
  logic [31:0] last_inst;
  int          epoch;
  int          cyc;
  int          consumed;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic bit stale_pending();
    foreach (mem_q[i]) if (mem_q[i].epoch != epoch) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_init();
    mem_q.delete();
    model_q.delete();
    m_fetch   = 64'h0;
    last_pc   = '0;
    last_inst = '0;
    epoch     = 0;
    cyc       = 0;
  endtask

  task automatic drive_idle();
    bus.redirect        = 1'b0;
    bus.redirect_pc     = '0;
    bus.imem_req_ready  = 1'b0;
    bus.imem_resp_valid = 1'b0;
    bus.imem_resp_inst  = '0;
    bus.inst_ready      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
  endtask

  // One cycle: called at a negedge, drives inputs, checks outputs, advances model, ends at next negedge.
  task automatic step(input bit redir, input logic [63:0] rpc, input bit iready,
                      input bit rready, input int lat);
    bit   resp, exp_rv, hs, dq;
    req_t r;
    ent_t e;
    resp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    bus.redirect        = redir;
    bus.redirect_pc     = rpc;
    bus.inst_ready      = iready;
    bus.imem_req_ready  = rready;
    bus.imem_resp_valid = resp;
    bus.imem_resp_inst  = resp ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
    #1;
    exp_rv = !stale_pending() && ((model_q.size() + mem_q.size()) < DEPTH);
    chk("req_valid", bus.imem_req_valid, exp_rv);
    if (exp_rv) chk("req_addr", bus.imem_req_addr, m_fetch);
    chk("inst_valid", bus.inst_valid, model_q.size() != 0);
    chk("inst_pc", bus.inst_pc, last_pc);
    chk("inst", bus.inst, last_inst);
    hs = exp_rv && rready;
    dq = (model_q.size() != 0) && iready;
    if (dq) consumed++;
    if (hs) begin
      r.addr = m_fetch; r.epoch = epoch; r.due = cyc + lat;
      mem_q.push_back(r);
      m_fetch += 64'd4;
    end
    if (resp) begin
      r = mem_q.pop_front();
      if (!redir && r.epoch == epoch) begin
        chk("no_resp_when_full", model_q.size() < DEPTH, 1'b1);
        e.pc = r.addr; e.inst = mem_word(r.addr);
        model_q.push_back(e);
      end
    end
    if (dq) void'(model_q.pop_front());
    if (redir) begin
      model_q.delete();
      epoch++;
      m_fetch = {rpc[63:2], 2'b00};
    end
    if (model_q.size() != 0) begin
      last_pc   = model_q[0].pc;
      last_inst = model_q[0].inst;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  // Steps normal traffic until the DUT raises a request; bounded.
  task automatic run_until_req(input int max_cycles, output int at_cyc, output logic [63:0] addr);
    at_cyc = -1;
    addr   = '1;
    for (int i = 0; i < max_cycles; i++) begin
      #1;
      if (bus.imem_req_valid) begin
        at_cyc = cyc;
        addr   = bus.imem_req_addr;
        return;
      end
      step(1'b0, '0, 1'b1, 1'b1, 2);
    end
  endtask

  vec_t        vt[9];
  int          at;
  logic [63:0] a;
  logic [63:0] first_pc;
  int          c0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    // rr rv ra ir | req_valid req_addr inst_valid inst_pc   (memory answers 1 cycle late, decode stalled)
    vt[0] = '{1'b1, 1'b0, 64'h0,  1'b0, 1'b1, 64'h0,  1'b0, 64'h0};
    vt[1] = '{1'b1, 1'b1, 64'h0,  1'b0, 1'b1, 64'h4,  1'b0, 64'h0};
    vt[2] = '{1'b1, 1'b1, 64'h4,  1'b0, 1'b1, 64'h8,  1'b1, 64'h0};
    vt[3] = '{1'b1, 1'b1, 64'h8,  1'b0, 1'b1, 64'hC,  1'b1, 64'h0};
    vt[4] = '{1'b1, 1'b1, 64'hC,  1'b0, 1'b0, 64'h10, 1'b1, 64'h0};
    vt[5] = '{1'b1, 1'b0, 64'h0,  1'b1, 1'b0, 64'h10, 1'b1, 64'h0};
    vt[6] = '{1'b1, 1'b0, 64'h0,  1'b0, 1'b1, 64'h10, 1'b1, 64'h4};
    vt[7] = '{1'b1, 1'b1, 64'h10, 1'b0, 1'b0, 64'h14, 1'b1, 64'h4};
    vt[8] = '{1'b1, 1'b0, 64'h0,  1'b0, 1'b0, 64'h14, 1'b1, 64'h4};

    consumed = 0;
    cyc = 0;
    rst_n = 1'b0;
    drive_idle();
    #3;
    chk("reset_inst_valid", bus.inst_valid, 1'b0);
    chk("reset_req_valid", bus.imem_req_valid, 1'b0);
    chk("reset_inst", bus.inst, 64'h0);
    chk("reset_inst_pc", bus.inst_pc, 64'h0);

    do_reset();
    foreach (vt[i]) begin
      bus.imem_req_ready  = vt[i].rr;
      bus.imem_resp_valid = vt[i].rv;
      bus.imem_resp_inst  = vt[i].rv ? mem_word(vt[i].ra) : 32'h0;
      bus.inst_ready      = vt[i].ir;
      #1;
      chk("vec_req_valid", bus.imem_req_valid, vt[i].e_rqv);
      chk("vec_req_addr", bus.imem_req_addr, vt[i].e_addr);
      chk("vec_inst_valid", bus.inst_valid, vt[i].e_iv);
      chk("vec_inst_pc", bus.inst_pc, vt[i].e_pc);
      chk("vec_inst", bus.inst, vt[i].e_iv ? 64'(mem_word(vt[i].e_pc)) : 64'h0);
      @(posedge clk);
      cyc++;
      @(negedge clk);
    end

    // Throughput with a 1-cycle memory and decode always ready.
    do_reset();
    repeat (4) step(1'b0, '0, 1'b1, 1'b1, 1);
    c0 = consumed;
    repeat (10) step(1'b0, '0, 1'b1, 1'b1, 1);
    chk("throughput", consumed - c0, 10);
    // Redirect together with a request handshake and a response.
    step(1'b1, 64'h3000, 1'b1, 1'b1, 1);
    #1;
    chk("flush_empty", bus.inst_valid, 1'b0);
    chk("drain_blocks_req", bus.imem_req_valid, 1'b0);
    repeat (8) step(1'b0, '0, 1'b1, 1'b1, 1);

    // Three requests in flight at 5-cycle latency, then redirect to an unaligned PC.
    do_reset();
    repeat (3) step(1'b0, '0, 1'b1, 1'b1, 5);
    step(1'b1, 64'h1003, 1'b1, 1'b0, 5);
    run_until_req(20, at, a);
    chk("redir_req_cycle", at, 8);
    chk("redir_req_addr", a, 64'h1000);
    first_pc = '1;
    for (int i = 0; i < 20 && first_pc == '1; i++) begin
      #1;
      if (bus.inst_valid) first_pc = bus.inst_pc;
      else step(1'b0, '0, 1'b1, 1'b1, 2);
    end
    chk("redir_first_inst_pc", first_pc, 64'h1000);

    // Second redirect while still draining.
    do_reset();
    repeat (3) step(1'b0, '0, 1'b1, 1'b1, 5);
    step(1'b1, 64'h1000, 1'b0, 1'b0, 5);
    step(1'b0, '0, 1'b0, 1'b1, 5);
    step(1'b1, 64'h2000, 1'b0, 1'b1, 5);
    run_until_req(20, at, a);
    chk("redir2_req_cycle", at, 8);
    chk("redir2_req_addr", a, 64'h2000);
    repeat (10) step(1'b0, '0, 1'b1, 1'b1, 3);

    // Asynchronous reset with a full queue.
    do_reset();
    repeat (8) step(1'b0, '0, 1'b0, 1'b1, 1);
    chk("full_inst_valid", bus.inst_valid, 1'b1);
    chk("full_no_req", bus.imem_req_valid, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_inst_valid", bus.inst_valid, 1'b0);
    chk("async_rst_req_valid", bus.imem_req_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_init();
    drive_idle();
    #1;
    chk("post_rst_req_valid", bus.imem_req_valid, 1'b1);
    chk("post_rst_req_addr", bus.imem_req_addr, 64'h0);
    repeat (6) step(1'b0, '0, 1'b1, 1'b1, 1);

    // Randomized traffic, including redirects near the top of the address space.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      bit          rd;
      logic [63:0] rp;
      rd = ($urandom_range(0, 29) == 0);
      rp = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15)))
                                       : {32'($urandom), 32'($urandom)};
      step(rd, rp, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(1, 6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
